// File: rtl/benes_pkg.sv
// Shared constants, types and inter-stage link tables for the 8-lane Benes fabric.
package benes_pkg;

  localparam int NLANES     = 8;
  localparam int NSTAGES    = 5;
  localparam int NSW        = 4;
  localparam int STATE_W    = 20;
  localparam int PKG_DATA_W = 8;

  typedef logic [PKG_DATA_W-1:0] lane_vec_t [NLANES];

  typedef enum logic [1:0] {UNCFG, RUN, DRAIN, LOAD} fsm_t;

  // Destination position of the word leaving position p of a stage.
  localparam int L0 [NLANES] = '{0, 4, 1, 5, 2, 6, 3, 7};
  localparam int L1 [NLANES] = '{0, 2, 1, 3, 4, 6, 5, 7};
  localparam int L2 [NLANES] = '{0, 2, 1, 3, 4, 6, 5, 7};
  localparam int L3 [NLANES] = '{0, 2, 4, 6, 1, 3, 5, 7};

  function automatic int link_dst(input int s, input int p);
    case (s)
      0:       return L0[p];
      1:       return L1[p];
      2:       return L2[p];
      default: return L3[p];
    endcase
  endfunction

endpackage

// File: rtl/benes_switch_stage.sv
// One layer of four 2x2 switches followed by its valid/data register; holds on !en_i.
module benes_switch_stage
  import benes_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     en_i,
  input  logic [NSW-1:0]           sw_i,
  input  logic                     vld_i,
  input  logic [NLANES*DATA_W-1:0] data_i,
  output logic                     vld_o,
  output logic [NLANES*DATA_W-1:0] data_o
);

  logic [NLANES*DATA_W-1:0] data_d;
  logic [NLANES*DATA_W-1:0] data_q;
  logic                     vld_q;

  always_comb begin
    data_d = data_i;
    for (int k = 0; k < NSW; k++) begin
      if (sw_i[k]) begin
        data_d[2*k*DATA_W +: DATA_W]     = data_i[(2*k+1)*DATA_W +: DATA_W];
        data_d[(2*k+1)*DATA_W +: DATA_W] = data_i[2*k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (en_i) begin
      vld_q  <= vld_i;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/benes_8_fabric.sv
// 5-stage registered Benes permutation fabric with drain-before-reconfigure control.
// Optional output handshake counter enabled by BENES_BEAT_CNT_EN.
module benes_8_fabric
  import benes_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = NLANES
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      cfg_valid,
  input  logic [STATE_W-1:0]        cfg_state,
  output logic                      cfg_ready,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
`ifdef BENES_BEAT_CNT_EN
  output logic [15:0]               beat_cnt,
`endif
  input  logic                      out_ready
);

  localparam int W = NLANES * DATA_W;

  fsm_t               state_q;
  logic [STATE_W-1:0] cfg_q;
  logic               cfg_ready_q;

  logic [W-1:0]         st_in  [NSTAGES];
  logic [W-1:0]         st_out [NSTAGES];
  logic [NSTAGES-1:0]   vld_in;
  logic [NSTAGES-1:0]   vld_out;
  logic                 stall;
  logic                 adv;
  logic                 all_empty;
  logic                 cfg_hs;
  logic                 in_hs;

  assign out_valid = vld_out[NSTAGES-1];
  assign out_data  = st_out[NSTAGES-1];
  assign stall     = out_valid && !out_ready;
  assign adv       = !stall;
  assign all_empty = (vld_out == '0);
  assign cfg_ready = cfg_ready_q;
  assign cfg_hs    = cfg_valid && cfg_ready_q;
  // A pending reconfiguration blocks new beats in the very cycle it appears.
  assign in_ready  = (state_q == RUN) && !stall && !cfg_valid;
  assign in_hs     = in_valid && in_ready;

  always_comb begin
    st_in[0]  = in_data;
    vld_in[0] = in_hs;
    for (int s = 1; s < NSTAGES; s++) begin
      st_in[s]  = '0;
      vld_in[s] = vld_out[s-1];
      for (int p = 0; p < NLANES; p++) begin
        st_in[s][link_dst(s-1, p)*DATA_W +: DATA_W] = st_out[s-1][p*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
    benes_switch_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk    (clk),
      .areset (areset),
      .en_i   (adv),
      .sw_i   (cfg_q[s*NSW +: NSW]),
      .vld_i  (vld_in[s]),
      .data_i (st_in[s]),
      .vld_o  (vld_out[s]),
      .data_o (st_out[s])
    );
  end

  // cfg_ready is registered so it reads low while reset is asserted.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= UNCFG;
      cfg_q       <= '0;
      cfg_ready_q <= 1'b0;
    end else begin
      case (state_q)
        UNCFG: begin
          cfg_ready_q <= 1'b1;
          if (cfg_hs) begin
            cfg_q       <= cfg_state;
            cfg_ready_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (cfg_valid) state_q <= DRAIN;
        end
        DRAIN: begin
          if (all_empty) begin
            cfg_ready_q <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (cfg_hs) begin
            cfg_q       <= cfg_state;
            cfg_ready_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        default: begin
          cfg_ready_q <= 1'b0;
          state_q     <= UNCFG;
        end
      endcase
    end
  end

`ifdef BENES_BEAT_CNT_EN
  logic [15:0] beat_cnt_q;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      beat_cnt_q <= '0;
    end else if (cfg_hs) begin
      beat_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule
